// File: rtl/ov7670_capture.sv
// OV7670 capture: synchronises the camera bus into clk, assembles 2-byte pixels, decimates and writes the frame buffer.
// Define OV7670_CAP_TESTPAT_EN to replace camera pixel data with a coordinate test pattern (timing unchanged).
module ov7670_capture #(
  parameter int c_cam_cols    = 160,
  parameter int c_cam_rows    = 120,
  parameter int c_scale       = 2,
  parameter int c_img_cols    = c_cam_cols / c_scale,
  parameter int c_img_rows    = c_cam_rows / c_scale,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ov7670_pclk,
  input  logic                     ov7670_href,
  input  logic                     ov7670_vsync,
  input  logic [7:0]               ov7670_d,
  input  logic                     rgbmode,
  output logic                     frame_we,
  output logic [c_nb_img_pxls-1:0] frame_addr,
  output logic [c_nb_buf-1:0]      frame_pixel,
  output logic                     frame_done
);

  localparam int c_nb_col = $clog2(c_cam_cols);
  localparam int c_nb_row = $clog2(c_cam_rows);

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

  state_t state_q, state_d;

  logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
  logic       href_s1_q, href_s2_q, href_prev_q;
  logic       vsync_s1_q, vsync_s2_q;
  logic [7:0] d_s1_q, d_s2_q;

  logic [c_nb_col-1:0]      cam_col_q, cam_col_d;
  logic [c_nb_row-1:0]      cam_row_q, cam_row_d;
  logic                     phase_q, phase_d;
  logic [7:0]               hold_q, hold_d;
  logic                     full_q, full_d;
  logic                     frame_we_q, frame_we_d;
  logic [c_nb_img_pxls-1:0] frame_addr_q, frame_addr_d;
  logic [c_nb_buf-1:0]      frame_pixel_q, frame_pixel_d;
  logic                     frame_done_q, frame_done_d;

  logic                pclk_edge;
  logic                href_fall;
  logic                keep;
  logic [c_nb_buf-1:0] pixel_new;

  assign pclk_edge = pclk_s2_q & ~pclk_prev_q;
  assign href_fall = href_prev_q & ~href_s2_q;
  assign keep      = ((int'(cam_col_q) % c_scale) == 0) && ((int'(cam_row_q) % c_scale) == 0);

`ifdef OV7670_CAP_TESTPAT_EN
  logic [c_nb_col-1:0] img_col;
  logic [c_nb_row-1:0] img_row;
  assign img_col   = c_nb_col'(int'(cam_col_q) / c_scale);
  assign img_row   = c_nb_row'(int'(cam_row_q) / c_scale);
  assign pixel_new = {img_col[3:0], img_row[3:0], 4'hF};
`else
  // YUYV sends Y first, so in gray mode the held byte is the luma
  assign pixel_new = rgbmode ? {hold_q[3:0], d_s2_q} : {4'h0, hold_q};
`endif

  always_comb begin
    state_d       = state_q;
    cam_col_d     = cam_col_q;
    cam_row_d     = cam_row_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    full_d        = full_q;
    frame_we_d    = 1'b0;
    frame_addr_d  = frame_addr_q;
    frame_pixel_d = frame_pixel_q;
    frame_done_d  = 1'b0;

    // Address advances after each write; the last buffer slot latches full instead of wrapping
    if (frame_we_q) begin
      if (frame_addr_q == c_nb_img_pxls'(c_img_pxls - 1)) begin
        full_d = 1'b1;
      end else begin
        frame_addr_d = frame_addr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (vsync_s2_q) begin
          state_d = VBLANK;
        end
      end
      VBLANK: begin
        if (!vsync_s2_q) begin
          state_d      = ACTIVE;
          cam_col_d    = '0;
          cam_row_d    = '0;
          phase_d      = 1'b0;
          full_d       = 1'b0;
          frame_addr_d = '0;
        end
      end
      ACTIVE: begin
        if (vsync_s2_q) begin
          state_d      = VBLANK;
          frame_done_d = 1'b1;
        end else if (href_fall) begin
          cam_col_d = '0;
          phase_d   = 1'b0;
          if (cam_row_q < c_nb_row'(c_cam_rows - 1)) begin
            cam_row_d = cam_row_q + 1'b1;
          end
        end else if (pclk_edge && href_s2_q) begin
          if (!phase_q) begin
            hold_d  = d_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (keep && !full_q) begin
              frame_we_d    = 1'b1;
              frame_pixel_d = pixel_new;
            end
            if (cam_col_q < c_nb_col'(c_cam_cols - 1)) begin
              cam_col_d = cam_col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1_q     <= 1'b0;
      pclk_s2_q     <= 1'b0;
      pclk_prev_q   <= 1'b0;
      href_s1_q     <= 1'b0;
      href_s2_q     <= 1'b0;
      href_prev_q   <= 1'b0;
      vsync_s1_q    <= 1'b0;
      vsync_s2_q    <= 1'b0;
      d_s1_q        <= '0;
      d_s2_q        <= '0;
      state_q       <= IDLE;
      cam_col_q     <= '0;
      cam_row_q     <= '0;
      phase_q       <= 1'b0;
      hold_q        <= '0;
      full_q        <= 1'b0;
      frame_we_q    <= 1'b0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      pclk_s1_q     <= ov7670_pclk;
      pclk_s2_q     <= pclk_s1_q;
      pclk_prev_q   <= pclk_s2_q;
      href_s1_q     <= ov7670_href;
      href_s2_q     <= href_s1_q;
      href_prev_q   <= href_s2_q;
      vsync_s1_q    <= ov7670_vsync;
      vsync_s2_q    <= vsync_s1_q;
      d_s1_q        <= ov7670_d;
      d_s2_q        <= d_s1_q;
      state_q       <= state_d;
      cam_col_q     <= cam_col_d;
      cam_row_q     <= cam_row_d;
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      full_q        <= full_d;
      frame_we_q    <= frame_we_d;
      frame_addr_q  <= frame_addr_d;
      frame_pixel_q <= frame_pixel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign frame_we    = frame_we_q;
  assign frame_addr  = frame_addr_q;
  assign frame_pixel = frame_pixel_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: expected writes are queued as camera bytes are driven, observed writes are queued by a monitor.
module tb_ov7670_capture;

  localparam int NPX = 4800;

  typedef struct {
    logic [12:0] addr;
    logic [11:0] pix;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pclk = 1'b0;
  logic        href = 1'b0;
  logic        vsync = 1'b0;
  logic [7:0]  d = 8'h00;
  logic        rgbmode = 1'b1;
  logic        frame_we;
  logic [12:0] frame_addr;
  logic [11:0] frame_pixel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_addr = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  ov7670_capture dut (
    .clk          (clk),
    .rst          (rst),
    .ov7670_pclk  (pclk),
    .ov7670_href  (href),
    .ov7670_vsync (vsync),
    .ov7670_d     (d),
    .rgbmode      (rgbmode),
    .frame_we     (frame_we),
    .frame_addr   (frame_addr),
    .frame_pixel  (frame_pixel),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_we) obs_q.push_back('{frame_addr, frame_pixel, cyc});
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [11:0] exp_pix(logic [7:0] b1, logic [7:0] b2, logic rgb, int col, int row);
    logic [7:0] c;
    logic [7:0] r;
    c = 8'(col / 2);
    r = 8'(row / 2);
`ifdef OV7670_CAP_TESTPAT_EN
    return {c[3:0], r[3:0], 4'hF};
`else
    if (c === 8'hFF && r === 8'hFF) return 12'h000;
    return rgb ? {b1[3:0], b2} : {4'h0, b1};
`endif
  endfunction

  // One camera byte: d/href set while pclk low, pclk high for two clk cycles
  task automatic send_byte(input logic [7:0] b, output int rise_cyc);
    @(negedge clk); pclk = 1'b0; d = b; href = 1'b1;
    @(negedge clk);
    @(negedge clk); pclk = 1'b1; rise_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2, input int col, input int row, input bit push);
    int r;
    send_byte(b1, r);
    send_byte(b2, r);
    if (push && (col % 2 == 0) && (row % 2 == 0) && exp_addr < NPX) begin
      exp_q.push_back('{13'(exp_addr), exp_pix(b1, b2, rgbmode, col, row), r + 3});
      exp_addr++;
    end
  endtask

  task automatic end_line();
    @(negedge clk); pclk = 1'b0; href = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input int row, input int npix, input int pat, input bit push);
    logic [7:0] b1, b2;
    for (int col = 0; col < npix; col++) begin
      case (pat)
        0:       begin b1 = 8'h0A; b2 = 8'hBC; end
        1:       begin b1 = 8'h5F; b2 = (col % 2 == 1) ? 8'h40 : 8'h80; end
        default: begin b1 = 8'(col * 5 + row); b2 = 8'((col * 3) ^ (row * 17)); end
      endcase
      send_pixel(b1, b2, col, row, push);
    end
    end_line();
  endtask

  // Line with href pulse but no pclk edges: only advances the row
  task automatic odd_row();
    @(negedge clk); pclk = 1'b0; href = 1'b1;
    repeat (2) @(negedge clk);
    end_line();
  endtask

  task automatic start_frame();
    @(negedge clk); vsync = 1'b1;
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    exp_addr = 0;
  endtask

  task automatic end_frame();
    @(negedge clk); vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (frame_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", frame_we); end
    n_cmp++; if (frame_addr !== 13'd0) begin n_bad++; $display("FAIL reset_addr: got %0d expected 0", frame_addr); end
    n_cmp++; if (frame_pixel !== 12'h000) begin n_bad++; $display("FAIL reset_pixel: got %h expected 000", frame_pixel); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_no_capture();
    vsync = 1'b0;
    send_line(0, 4, 0, 1'b0);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL idle_writes: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (frame_addr !== 13'd0) begin n_bad++; $display("FAIL idle_addr: got %0d expected 0", frame_addr); end
    obs_q.delete();
  endtask

  task automatic test_rgb_frame();
    int base;
    wr_t e, o;
    rgbmode = 1'b1;
    base = done_cnt;
    start_frame();
    for (int row = 0; row < 120; row++) begin
      if (row % 2 == 0) send_line(row, 160, 0, 1'b1);
      else odd_row();
    end
    end_frame();
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL rgb_done_count: got %0d expected 1", done_cnt - base); end
    n_cmp++; if (frame_addr !== 13'd4799) begin n_bad++; $display("FAIL rgb_last_addr: got %0d expected 4799", frame_addr); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rgb_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.pix !== e.pix || o.cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL rgb_write: got addr=%0d pix=%h cyc=%0d expected addr=%0d pix=%h cyc=%0d", o.addr, o.pix, o.cyc, e.addr, e.pix, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_yuyv_short_line();
    int base, r;
    wr_t e, o;
    rgbmode = 1'b0;
    base = done_cnt;
    start_frame();
    send_line(0, 160, 1, 1'b1);
    send_line(1, 40, 1, 1'b1);
    send_pixel(8'h5F, 8'h80, 0, 2, 1'b1);
    send_byte(8'h5F, r);
    end_line();
    odd_row();
    rgbmode = 1'b1;
    send_line(4, 4, 2, 1'b1);
    end_frame();
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL yuyv_done_count: got %0d expected 1", done_cnt - base); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL yuyv_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.pix !== e.pix || o.cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL yuyv_write: got addr=%0d pix=%h cyc=%0d expected addr=%0d pix=%h cyc=%0d", o.addr, o.pix, o.cyc, e.addr, e.pix, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_short_frame();
    int base;
    wr_t e, o;
    rgbmode = 1'b1;
    base = done_cnt;
    start_frame();
    for (int row = 0; row < 10; row++) begin
      if (row % 2 == 0) send_line(row, 160, 2, 1'b1);
      else odd_row();
    end
    end_frame();
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL short_done_count: got %0d expected 1", done_cnt - base); end
    n_cmp++; if (frame_addr !== 13'd400) begin n_bad++; $display("FAIL short_final_addr: got %0d expected 400", frame_addr); end
    n_cmp++; if (obs_q.size() !== 400) begin n_bad++; $display("FAIL short_write_count: got %0d expected 400", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.pix !== e.pix || o.cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL short_write: got addr=%0d pix=%h cyc=%0d expected addr=%0d pix=%h cyc=%0d", o.addr, o.pix, o.cyc, e.addr, e.pix, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_rst_mid_line();
    int base;
    wr_t e, o;
    rgbmode = 1'b1;
    start_frame();
    send_line(0, 160, 2, 1'b1);
    odd_row();
    for (int col = 0; col < 10; col++) send_pixel(8'(col * 5 + 2), 8'((col * 3) ^ 34), col, 2, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (frame_addr !== 13'd85) begin n_bad++; $display("FAIL rst_pre_addr: got %0d expected 85", frame_addr); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (frame_we !== 1'b0) begin n_bad++; $display("FAIL rst_async_we: got %b expected 0", frame_we); end
    n_cmp++; if (frame_addr !== 13'd0) begin n_bad++; $display("FAIL rst_async_addr: got %0d expected 0", frame_addr); end
    n_cmp++; if (frame_pixel !== 12'h000) begin n_bad++; $display("FAIL rst_async_pixel: got %h expected 000", frame_pixel); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_async_done: got %b expected 0", frame_done); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rst_pre_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.pix !== e.pix || o.cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL rst_pre_write: got addr=%0d pix=%h cyc=%0d expected addr=%0d pix=%h cyc=%0d", o.addr, o.pix, o.cyc, e.addr, e.pix, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    @(negedge clk); pclk = 1'b0; href = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_line(0, 4, 2, 1'b0);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rst_post_idle_writes: got %0d expected 0", obs_q.size()); end
    obs_q.delete();
    // Back-to-back: a fresh frame after reset restarts at address 0
    base = done_cnt;
    start_frame();
    send_line(0, 6, 2, 1'b1);
    end_frame();
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL rst_next_done_count: got %0d expected 1", done_cnt - base); end
    n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL rst_next_write_count: got %0d expected 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.pix !== e.pix || o.cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL rst_next_write: got addr=%0d pix=%h cyc=%0d expected addr=%0d pix=%h cyc=%0d", o.addr, o.pix, o.cyc, e.addr, e.pix, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_idle_no_capture();
    test_yuyv_short_line();
    test_short_frame();
    test_rst_mid_line();
    test_rgb_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
